// File: rtl/output_port_arbiter_if.sv
// output_port_arbiter_if
//   Bundles the request side (input buffers -> arbiter) and the link side
//   (arbiter -> neighbouring router/NIC) of one output port.
//   req      : per-requester request, flit valid for the internal VC
//   req_data : requester i flit in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   gnt      : one-hot combinational grant, requester pops on that edge
//   so       : send-out, external-VC slot holds a flit
//   ri       : downstream ready for the current external VC
//   do_flit  : external-VC slot flit ("do" is a reserved word in SV)
//   Modports: master = arbiter side, slave = requesters/link partner side.
interface output_port_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic                          so;
    logic                          ri;
    logic [DATA_WIDTH-1:0]         do_flit;

    modport master (input req, req_data, ri, output gnt, so, do_flit);
    modport slave  (output req, req_data, ri, input gnt, so, do_flit);
endinterface

// File: rtl/output_port_arbiter.sv
// output_port_arbiter
//   Round-robin arbiter plus two-VC (even/odd) output buffer for one router
//   output link. polarity selects which slot is internal (filled by grants)
//   and which is external (drained over the so/ri handshake):
//   iv = polarity, ev = ~polarity.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     polarity   : global VC phase
//     bus        : output_port_arbiter_if.master (req/req_data/gnt, so/ri/do_flit)
//     pkt_cnt    : 16-bit wrapping count of so&&ri transfers, only present
//                  when OUTPUT_PORT_ARB_PKT_CNT_EN is defined
module output_port_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REQ    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  polarity,
    output_port_arbiter_if.master bus
`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
    ,
    output logic [15:0]           pkt_cnt
`endif
);
    localparam int          PW = $clog2(NUM_REQ);
    localparam int unsigned NR = NUM_REQ;

    logic [1:0]                 full_q, full_d;
    logic [1:0][DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0][PW-1:0]         ptr_q, ptr_d;

    logic               iv, ev;
    logic               found;
    logic [PW-1:0]      win;
    logic [PW-1:0]      idx;
    logic [NUM_REQ-1:0] gnt_c;

`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;
`endif

    always_comb begin
        iv     = polarity;
        ev     = ~polarity;
        found  = 1'b0;
        win    = '0;
        idx    = '0;
        gnt_c  = '0;
        full_d = full_q;
        data_d = data_q;
        ptr_d  = ptr_q;

        // Rotating search from the internal VC's pointer; first hit wins.
        if (!reset && !full_q[iv]) begin
            for (int unsigned off = 0; off < NR; off++) begin
                idx = PW'((32'(ptr_q[iv]) + off) % NR);
                if (!found && bus.req[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end

        if (found) begin
            gnt_c[win]  = 1'b1;
            full_d[iv]  = 1'b1;
            data_d[iv]  = bus.req_data[32'(win)*DATA_WIDTH +: DATA_WIDTH];
            ptr_d[iv]   = (32'(win) == NR - 1) ? '0 : PW'(win + 1'b1);
        end

        // Drain touches the other slot, so it never conflicts with the fill.
        if (full_q[ev] && bus.ri) begin
            full_d[ev] = 1'b0;
        end

`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
        pkt_cnt_d = pkt_cnt_q;
        if (full_q[ev] && bus.ri) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            data_q    <= '0;
            ptr_q     <= '0;
`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
            pkt_cnt_q <= '0;
`endif
        end else begin
            full_q    <= full_d;
            data_q    <= data_d;
            ptr_q     <= ptr_d;
`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
            pkt_cnt_q <= pkt_cnt_d;
`endif
        end
    end

    assign bus.gnt     = gnt_c;
    assign bus.so      = full_q[ev];
    assign bus.do_flit = data_q[ev];

`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
    assign pkt_cnt = pkt_cnt_q;
`endif
endmodule

// File: tb/tb_output_port_arbiter.sv
module tb_output_port_arbiter;
    localparam int DW = 64;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic reset;
    logic polarity;

    always #5 clk = ~clk;

    output_port_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
    logic [15:0] pkt_cnt;
`endif

    output_port_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk      (clk),
        .reset    (reset),
        .polarity (polarity),
        .bus      (bus)
`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
        ,
        .pkt_cnt  (pkt_cnt)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference model: slot contents, last granted index per VC, transfer count.
    bit          m_full[2];
    logic [63:0] m_data[2];
    int          m_last[2];
    int unsigned m_cnt;

    logic [DW-1:0] flit[NR];
    bit            fixed_en;
    logic [63:0]   fixed_flit;
    int            exp_k;
    logic          cur_rst, cur_pol, cur_ri;

    function automatic void model_reset();
        for (int v = 0; v < 2; v++) begin
            m_full[v] = 1'b0;
            m_data[v] = '0;
            m_last[v] = NR - 1;
        end
        m_cnt = 0;
    endfunction

    // Winner is the first requester strictly after the last one served on this VC.
    function automatic int pick(input logic [NR-1:0] rq, input int last);
        for (int s = 1; s <= NR; s++) begin
            int i;
            i = (last + s) % NR;
            if (rq[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive(input logic rst, input logic [NR-1:0] rq, input logic pol, input logic r);
        @(negedge clk);
        cur_rst  = rst;
        cur_pol  = pol;
        cur_ri   = r;
        reset    = rst;
        polarity = pol;
        bus.req  = rq;
        bus.ri   = r;
        for (int k = 0; k < NR; k++) begin
            flit[k] = fixed_en ? fixed_flit : {$urandom, $urandom};
            bus.req_data[k*DW +: DW] = flit[k];
        end
        #1;
        exp_k = (rst || m_full[pol]) ? -1 : pick(rq, m_last[pol]);
        check("gnt", 64'(bus.gnt), (exp_k < 0) ? 64'd0 : (64'd1 << exp_k));
        check("so", 64'(bus.so), 64'(m_full[!pol]));
        check("do", bus.do_flit, m_data[!pol]);
`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
        check("pkt_cnt", 64'(pkt_cnt), 64'(m_cnt % 65536));
`endif
    endtask

    task automatic tick();
        bit ep;
        bit drain;
        @(posedge clk);
        if (cur_rst) begin
            model_reset();
        end else begin
            ep    = !cur_pol;
            drain = m_full[ep] && cur_ri;
            if (exp_k >= 0) begin
                m_full[cur_pol] = 1'b1;
                m_data[cur_pol] = flit[exp_k];
                m_last[cur_pol] = exp_k;
            end
            if (drain) begin
                m_full[ep] = 1'b0;
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic rst, input logic [NR-1:0] rq, input logic pol, input logic r);
        drive(rst, rq, pol, r);
        tick();
    endtask

    initial begin
        logic [63:0] prev;
        reset        = 1'b1;
        polarity     = 1'b0;
        bus.req      = '0;
        bus.ri       = 1'b0;
        bus.req_data = '0;
        fixed_en     = 1'b0;
        fixed_flit   = '0;
        exp_k        = -1;
        prev         = '0;
        cur_rst      = 1'b1;
        cur_pol      = 1'b0;
        cur_ri       = 1'b0;
        model_reset();
        @(posedge clk);

        // Reset held two cycles with all requests up.
        repeat (2) begin
            drive(1'b1, 4'hF, 1'b0, 1'b1);
            check("rst_gnt", 64'(bus.gnt), 64'd0);
            check("rst_so", 64'(bus.so), 64'd0);
            check("rst_do", bus.do_flit, 64'd0);
            tick();
        end

        // Round-robin with both VCs alternating, all requesting.
        for (int i = 0; i < 13; i++) begin
            drive(1'b0, 4'hF, 1'(i % 2), 1'b1);
            check("rr_gnt", 64'(bus.gnt), 64'd1 << ((i / 2) % 4));
            if (i > 0) check("rr_do", bus.do_flit, prev);
            prev = flit[(i / 2) % 4];
            tick();
        end

        // Even pointer now 3: 0101 wraps past 3 to 0, then 2.
        step(1'b0, 4'hF, 1'b1, 1'b1);
        drive(1'b0, 4'b0101, 1'b0, 1'b1);
        check("wrap_gnt", 64'(bus.gnt), 64'd1);
        tick();
        step(1'b0, 4'hF, 1'b1, 1'b1);
        drive(1'b0, 4'b0101, 1'b0, 1'b1);
        check("wrap_next", 64'(bus.gnt), 64'd4);
        tick();

        // Back-pressure on the even VC.
        step(1'b0, 4'hF, 1'b1, 1'b1);
        fixed_en   = 1'b1;
        fixed_flit = 64'hDEAD_BEEF_0000_0001;
        step(1'b0, 4'hF, 1'b0, 1'b1);
        fixed_en   = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j % 2 == 0) begin
                drive(1'b0, 4'hF, 1'b1, 1'b0);
                check("bp_so", 64'(bus.so), 64'd1);
                check("bp_do", bus.do_flit, 64'hDEAD_BEEF_0000_0001);
                check("bp_odd_gnt", 64'(bus.gnt != 0), 64'd1);
            end else begin
                drive(1'b0, 4'hF, 1'b0, 1'b1);
                check("bp_even_blocked", 64'(bus.gnt), 64'd0);
            end
            tick();
        end
        drive(1'b0, 4'hF, 1'b1, 1'b1);
        check("bp_release_do", bus.do_flit, 64'hDEAD_BEEF_0000_0001);
        tick();
        drive(1'b0, 4'hF, 1'b0, 1'b1);
        check("bp_resume", 64'(bus.gnt != 0), 64'd1);
        tick();

        // Fill both slots, then reset for one cycle.
        step(1'b0, 4'hF, 1'b1, 1'b0);
        drive(1'b0, 4'hF, 1'b0, 1'b0);
        check("pre_rst_so", 64'(bus.so), 64'd1);
        check("pre_rst_gnt", 64'(bus.gnt), 64'd0);
        tick();
        step(1'b1, 4'hF, 1'b0, 1'b0);
        drive(1'b0, 4'hF, 1'b0, 1'b1);
        check("post_rst_so", 64'(bus.so), 64'd0);
        check("post_rst_gnt_even", 64'(bus.gnt), 64'd1);
        tick();
        drive(1'b0, 4'hF, 1'b1, 1'b1);
        check("post_rst_gnt_odd", 64'(bus.gnt), 64'd1);
        tick();

        // Random traffic with occasional resets.
        repeat (400) begin
            step(1'($urandom_range(0, 63) == 0), 4'($urandom), 1'($urandom), 1'($urandom));
        end

`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
        step(1'b1, 4'h0, 1'b0, 1'b0);
        for (int c = 0; c < 80000 && m_cnt < 70000; c++) begin
            step(1'b0, 4'hF, 1'(c % 2), (c % 16 == 15) ? 1'b0 : 1'b1);
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        check("pkt_cnt_wrap", 64'(pkt_cnt), 64'd4464);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
